// File: rtl/pixel_fifo_rd_scheduler.sv
// Read-side scheduler for the RGB pixel FIFO feeding the VGA output.
// Waits for a frame boundary with enough prefill before streaming, emits
// black on underrun, re-aligns to the next frame and counts underruns.
module pixel_fifo_rd_scheduler #(
   parameter int DATA_W        = 10,
   parameter int USEDW_W       = 9,
   parameter int PREFILL_LEVEL = 256,
   parameter int ERR_W         = 16
) (
   input  logic               CLK_2,
   input  logic               RESET_N,
   input  logic               iEN,
   input  logic               iFRAME_START,
   input  logic               iPIX_REQ,
   input  logic               iRDEMPTY,
   input  logic [USEDW_W-1:0] iRDUSEDW,
   input  logic [DATA_W-1:0]  iQ_RED,
   input  logic [DATA_W-1:0]  iQ_GREEN,
   input  logic [DATA_W-1:0]  iQ_BLUE,
   output logic               oRDREQ,
   output logic [DATA_W-1:0]  oRED,
   output logic [DATA_W-1:0]  oGREEN,
   output logic [DATA_W-1:0]  oBLUE,
   output logic               oVALID,
   output logic               oSTREAMING,
   output logic [ERR_W-1:0]   oUNDERRUN_CNT,
   output logic [2:0]         oSTATE
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_FRAME = 3'd1,
      PREFILL    = 3'd2,
      STREAM     = 3'd3,
      RESYNC     = 3'd4
   } state_t;

   localparam logic [31:0] PREFILL_THR = 32'(PREFILL_LEVEL);

   state_t      state;
   logic        s1_req;
   logic        s1_took;
   logic        underrun;
   logic        prefill_ok;
   logic [31:0] usedw_ext;

   assign usedw_ext  = 32'(iRDUSEDW);
   assign prefill_ok = (usedw_ext >= PREFILL_THR);
   assign underrun   = (state == STREAM) && iPIX_REQ && iRDEMPTY;

   // Read request: serve pixels while streaming, drain stale data in RESYNC
   always_comb begin
      oRDREQ = 1'b0;
      if (!iRDEMPTY) begin
         if (state == STREAM)
            oRDREQ = iPIX_REQ;
         else if (state == RESYNC)
            oRDREQ = 1'b1;
      end
   end

   assign oSTREAMING = (state == STREAM);
   assign oSTATE     = state;

   // State machine; a low enable forces IDLE ahead of every other transition
   always_ff @(posedge CLK_2 or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= IDLE;
      end else if (!iEN) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:       state <= WAIT_FRAME;
            WAIT_FRAME: if (iFRAME_START) state <= PREFILL;
            PREFILL:    if (iFRAME_START && prefill_ok) state <= STREAM;
            STREAM:     if (underrun) state <= RESYNC;
            RESYNC:     if (iFRAME_START) state <= PREFILL;
            default:    state <= IDLE;
         endcase
      end
   end

   // Saturating underrun counter, bumped only on the STREAM -> RESYNC edge
   always_ff @(posedge CLK_2 or negedge RESET_N) begin
      if (!RESET_N)
         oUNDERRUN_CNT <= '0;
      else if (iEN && underrun && (oUNDERRUN_CNT != '1))
         oUNDERRUN_CNT <= oUNDERRUN_CNT + ERR_W'(1);
   end

   // Stage 1: remember whether each request was backed by a real FIFO read
   always_ff @(posedge CLK_2 or negedge RESET_N) begin
      if (!RESET_N) begin
         s1_req  <= 1'b0;
         s1_took <= 1'b0;
      end else begin
         s1_req  <= iPIX_REQ;
         s1_took <= oRDREQ && (state == STREAM);
      end
   end

   // Stage 2: answer every request, with FIFO data or black, holding otherwise
   always_ff @(posedge CLK_2 or negedge RESET_N) begin
      if (!RESET_N) begin
         oVALID <= 1'b0;
         oRED   <= '0;
         oGREEN <= '0;
         oBLUE  <= '0;
      end else begin
         oVALID <= s1_req;
         if (s1_req) begin
            if (s1_took) begin
               oRED   <= iQ_RED;
               oGREEN <= iQ_GREEN;
               oBLUE  <= iQ_BLUE;
            end else begin
               oRED   <= '0;
               oGREEN <= '0;
               oBLUE  <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_pixel_fifo_rd_scheduler.sv
// Directed bench for pixel_fifo_rd_scheduler with a pixel scoreboard:
// expected pixels are queued when requested and matched when oVALID appears.
module tb_pixel_fifo_rd_scheduler;

   localparam int DATA_W  = 10;
   localparam int USEDW_W = 9;
   localparam int ERR_W   = 2;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               en, frame, req, empty;
   logic [USEDW_W-1:0] usedw;
   logic [DATA_W-1:0]  q_r, q_g, q_b;
   logic               rdreq, valid, streaming;
   logic [DATA_W-1:0]  o_r, o_g, o_b;
   logic [ERR_W-1:0]   cnt;
   logic [2:0]         st;

   int unsigned cyc = 0;
   int ncmp = 0;
   int nerr = 0;

   typedef struct {
      int unsigned     due;
      logic [29:0]     pix;
   } exp_t;
   exp_t sb[$];

   pixel_fifo_rd_scheduler #(
      .DATA_W(DATA_W),
      .USEDW_W(USEDW_W),
      .PREFILL_LEVEL(256),
      .ERR_W(ERR_W)
   ) dut (
      .CLK_2(clk),
      .RESET_N(rst_n),
      .iEN(en),
      .iFRAME_START(frame),
      .iPIX_REQ(req),
      .iRDEMPTY(empty),
      .iRDUSEDW(usedw),
      .iQ_RED(q_r),
      .iQ_GREEN(q_g),
      .iQ_BLUE(q_b),
      .oRDREQ(rdreq),
      .oRED(o_r),
      .oGREEN(o_g),
      .oBLUE(o_b),
      .oVALID(valid),
      .oSTREAMING(streaming),
      .oUNDERRUN_CNT(cnt),
      .oSTATE(st)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [29:0] pat(input int i);
      logic [9:0] k;
      k = 10'(i);
      return {10'h3FF ^ k, 10'h155 ^ k, 10'h0AA ^ k};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [29:0] pix);
      exp_t e;
      e.due = cyc + 2;
      e.pix = pix;
      sb.push_back(e);
   endtask

   task automatic set_q(input logic [29:0] v);
      {q_r, q_g, q_b} = v;
   endtask

   // Force one underrun from STREAM: request while empty
   task automatic do_underrun();
      empty = 1'b1;
      req   = 1'b1;
      #1 check("rdreq_on_empty", 32'(rdreq), 32'd0);
      push('0);
      tick();
      req   = 1'b0;
      empty = 1'b0;
   endtask

   // From RESYNC, walk back into STREAM across two frame pulses
   task automatic resync_to_stream();
      frame = 1'b1;
      tick();
      frame = 1'b0;
      check("resync_to_prefill", 32'(st), 32'd2);
      usedw = 9'd256;
      frame = 1'b1;
      tick();
      frame = 1'b0;
      check("prefill_to_stream", 32'(st), 32'd3);
   endtask

   // Scoreboard monitor: every negedge checks oVALID against the queue head
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            check("valid", 32'(valid), 32'd1);
            check("pixel", 32'({o_r, o_g, o_b}), 32'(e.pix));
         end else begin
            check("no_valid", 32'(valid), 32'd0);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      en = 1'b0; frame = 1'b0; req = 1'b0; empty = 1'b1;
      usedw = '0;
      set_q('0);
      repeat (3) tick();
      check("rst_state", 32'(st), 32'd0);
      check("rst_rdreq", 32'(rdreq), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_rgb", 32'({o_r, o_g, o_b}), 32'd0);
      check("rst_cnt", 32'(cnt), 32'd0);
      check("rst_streaming", 32'(streaming), 32'd0);

      rst_n = 1'b1;
      tick();
      check("idle_hold", 32'(st), 32'd0);

      en = 1'b1; usedw = 9'd300; empty = 1'b0;
      tick();
      check("to_wait_frame", 32'(st), 32'd1);
      frame = 1'b1;
      tick();
      frame = 1'b0;
      check("to_prefill", 32'(st), 32'd2);

      // Request during PREFILL: no read, black pixel
      req = 1'b1;
      #1 check("prefill_rdreq", 32'(rdreq), 32'd0);
      push('0);
      tick();
      req = 1'b0;

      frame = 1'b1;
      tick();
      frame = 1'b0;
      check("to_stream", 32'(st), 32'd3);
      check("streaming", 32'(streaming), 32'd1);

      // Four back-to-back reads; q follows each read by one cycle
      for (int i = 0; i < 4; i++) begin
         req = 1'b1;
         set_q(i == 0 ? 30'd0 : pat(i - 1));
         #1 check("stream_rdreq", 32'(rdreq), 32'd1);
         push(pat(i));
         tick();
      end
      req = 1'b0;
      set_q(pat(3));
      #1 check("stream_idle_rdreq", 32'(rdreq), 32'd0);
      tick();
      set_q('0);

      // Underrun coinciding with a frame pulse: pulse is consumed
      frame = 1'b1;
      do_underrun();
      frame = 1'b0;
      check("to_resync", 32'(st), 32'd4);
      check("cnt_1", 32'(cnt), 32'd1);
      check("not_streaming", 32'(streaming), 32'd0);

      // Drain in RESYNC; a request here is answered black
      req = 1'b1;
      #1 check("drain_rdreq", 32'(rdreq), 32'd1);
      push('0);
      tick();
      req = 1'b0;
      empty = 1'b1;
      #1 check("drain_empty_rdreq", 32'(rdreq), 32'd0);
      tick();
      check("resync_hold", 32'(st), 32'd4);
      empty = 1'b0;

      frame = 1'b1;
      tick();
      frame = 1'b0;
      check("resync_to_prefill", 32'(st), 32'd2);

      // Prefill threshold boundary
      usedw = 9'd255;
      frame = 1'b1;
      tick();
      frame = 1'b0;
      check("prefill_255_hold", 32'(st), 32'd2);
      tick();
      usedw = 9'd256;
      frame = 1'b1;
      tick();
      frame = 1'b0;
      check("prefill_256_stream", 32'(st), 32'd3);

      // Four more underruns: 2-bit counter saturates at 3
      for (int n = 2; n <= 5; n++) begin
         do_underrun();
         check("sat_state", 32'(st), 32'd4);
         check("sat_cnt", 32'(cnt), (n < 3) ? 32'(n) : 32'd3);
         resync_to_stream();
      end

      // Enable drops with two requests in flight
      req = 1'b1;
      set_q('0);
      push(pat(10));
      tick();
      set_q(pat(10));
      en = 1'b0;
      #1 check("en_drop_rdreq", 32'(rdreq), 32'd1);
      push(pat(11));
      tick();
      check("to_idle", 32'(st), 32'd0);
      set_q(pat(11));
      #1 check("idle_rdreq", 32'(rdreq), 32'd0);
      push('0);
      tick();
      req = 1'b0;
      set_q('0);
      repeat (4) tick();
      check("idle_rdreq_later", 32'(rdreq), 32'd0);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
